player_input_ctrl: RTL and testbench

Front-end input conditioner for the two-player Pokemon battle. It turns six raw push-buttons (up, down and shoot for each player) into clean control signals for the game-logic stage. Movement comes out as one-cycle pulses, with optional auto-repeat. Shoot comes out as a held request level, long enough for the 20 Hz projectile engine downstream to sample it at least once.

---
 rtl/pokemon_input_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 38 +++
 rtl/player_input_ctrl.sv | 170 +++++++++++++++++
 tb/tb_player_input_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pokemon_input_pkg.sv
// Shared types and constants for the two-player battle input front end.
package pokemon_input_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } move_state_e;

    // Bit positions of each button inside a player's 3-bit button vector.
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int SHOOT = 2;

    localparam int DEF_DEB_CYCLES    = 100000;
    localparam int DEF_REPEAT_DELAY  = 40000000;
    localparam int DEF_REPEAT_PERIOD = 15000000;
    localparam int DEF_SHOOT_HOLD    = 5000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; db changes only after
// the synchronized input has differed from it for DEB_CYCLES consecutive cycles.
module btn_debounce
    import pokemon_input_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic db
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, like real hardware.
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] == db) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db    <= ~db;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Conditions six raw buttons into lane-move pulses and shoot request levels.
// Define PLAYER_INPUT_AUTOREPEAT_EN to build the hold-to-repeat movement FSM.
module player_input_ctrl
    import pokemon_input_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int SHOOT_HOLD    = DEF_SHOOT_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic game_en,
    input  logic btn_p1_up,
    input  logic btn_p1_down,
    input  logic btn_p1_shoot,
    input  logic btn_p2_up,
    input  logic btn_p2_down,
    input  logic btn_p2_shoot,
    output logic player1_up,
    output logic player1_down,
    output logic player2_up,
    output logic player2_down,
    output logic player1Shoot,
    output logic player2Shoot
);

    localparam int SW = $clog2(SHOOT_HOLD + 1);

    logic [2:0] raw [2];
    logic [1:0] mv_up, mv_down, shoot_req;

    assign raw[0] = {btn_p1_shoot, btn_p1_down, btn_p1_up};
    assign raw[1] = {btn_p2_shoot, btn_p2_down, btn_p2_up};

    assign player1_up   = mv_up[0];
    assign player1_down = mv_down[0];
    assign player2_up   = mv_up[1];
    assign player2_down = mv_down[1];
    assign player1Shoot = shoot_req[0];
    assign player2Shoot = shoot_req[1];

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [2:0]    db, db_prev_q;
        logic          rise_up, rise_down, rise_shoot, start_up, start_down;
        logic          up_d, down_d, up_q, down_q;
        logic          shoot_q;
        logic [SW-1:0] shoot_cnt_q;

        for (genvar b = 0; b < 3; b++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (raw[p][b]),
                .db   (db[b])
            );
        end

        assign rise_up    = db[UP]    & ~db_prev_q[UP];
        assign rise_down  = db[DOWN]  & ~db_prev_q[DOWN];
        assign rise_shoot = db[SHOOT] & ~db_prev_q[SHOOT];
        // A new press only counts while the opposite direction is released.
        assign start_up   = rise_up   & ~db[DOWN];
        assign start_down = rise_down & ~db[UP];

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX + 1);

        move_state_e   state_q, state_d, state_eff;
        logic          held_up_q, held_up_d, held;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                held_up_q <= 1'b0;
                rep_cnt_q <= '0;
            end else begin
                state_q   <= state_d;
                held_up_q <= held_up_d;
                rep_cnt_q <= rep_cnt_d;
            end
        end

        always_comb begin
            // NOTE: every signal gets a default first so no branch can infer a latch.
            state_d   = state_q;
            held_up_d = held_up_q;
            rep_cnt_d = rep_cnt_q;
            up_d      = 1'b0;
            down_d    = 1'b0;
            held      = held_up_q ? db[UP] : db[DOWN];
            // Release or conflict aborts a hold before this cycle's action is chosen.
            state_eff = (!held || (db[UP] && db[DOWN])) ? IDLE : state_q;
            if (!game_en) begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end else begin
                case (state_eff)
                    HELD_DELAY: begin
                        if (rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
                            up_d      = held_up_q;
                            down_d    = ~held_up_q;
                            rep_cnt_d = '0;
                            state_d   = HELD_REPEAT;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
                    end
                    HELD_REPEAT: begin
                        if (rep_cnt_q == RW'(REPEAT_PERIOD - 1)) begin
                            up_d      = held_up_q;
                            down_d    = ~held_up_q;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        rep_cnt_d = '0;
                        if (start_up) begin
                            up_d      = 1'b1;
                            held_up_d = 1'b1;
                            state_d   = HELD_DELAY;
                        end else if (start_down) begin
                            down_d    = 1'b1;
                            held_up_d = 1'b0;
                            state_d   = HELD_DELAY;
                        end
                    end
                endcase
            end
        end
`else
        assign up_d   = game_en & start_up;
        assign down_d = game_en & start_down;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_prev_q   <= '0;
                up_q        <= 1'b0;
                down_q      <= 1'b0;
                shoot_q     <= 1'b0;
                shoot_cnt_q <= '0;
            end else begin
                db_prev_q <= db;
                up_q      <= up_d;
                down_q    <= down_d;
                if (!game_en) begin
                    shoot_q     <= 1'b0;
                    shoot_cnt_q <= '0;
                end else if (shoot_q) begin
                    if (shoot_cnt_q == '0) shoot_q <= 1'b0;
                    else                   shoot_cnt_q <= shoot_cnt_q - SW'(1);
                end else if (rise_shoot) begin
                    shoot_q     <= 1'b1;
                    shoot_cnt_q <= SW'(SHOOT_HOLD - 1);
                end
            end
        end

        assign mv_up[p]     = up_q;
        assign mv_down[p]   = down_q;
        assign shoot_req[p] = shoot_q;
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with an edge-indexed behavioural model.
module tb_player_input_ctrl;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int HOLD = 6;

    logic clk = 1'b0, rst_n = 1'b0, game_en = 1'b1;
    logic btn_p1_up = 1'b0, btn_p1_down = 1'b0, btn_p1_shoot = 1'b0;
    logic btn_p2_up = 1'b0, btn_p2_down = 1'b0, btn_p2_shoot = 1'b0;
    logic player1_up, player1_down, player2_up, player2_down, player1Shoot, player2Shoot;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    player_input_ctrl #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SHOOT_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_en(game_en),
        .btn_p1_up(btn_p1_up), .btn_p1_down(btn_p1_down), .btn_p1_shoot(btn_p1_shoot),
        .btn_p2_up(btn_p2_up), .btn_p2_down(btn_p2_down), .btn_p2_shoot(btn_p2_shoot),
        .player1_up(player1_up), .player1_down(player1_down),
        .player2_up(player2_up), .player2_down(player2_down),
        .player1Shoot(player1Shoot), .player2Shoot(player2Shoot)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, indexed by clock edge ----------------
    // A debounced level flips at edge n when the raw samples taken at edges
    // n-2 .. n-DEB-1 all differ from it and at least DEB edges passed since the
    // last flip. Outputs are then derived from press episodes and edge offsets.
    bit [31:0] m_hist [2][3];
    bit        m_db   [2][3];
    bit        m_dbp  [2][3];
    int        m_since[2][3];
    bit        m_mv_act[2], m_mv_up[2], m_sh_act[2];
    int        m_mv_t0[2], m_sh_t0[2];
    bit        e_up[2], e_down[2], e_sh[2];
    int        m_n;
    logic [2:0] m_raw [2];

    task automatic model_reset();
        m_n = 0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 3; b++) begin
                m_hist[p][b] = '0; m_db[p][b] = 0; m_dbp[p][b] = 0; m_since[p][b] = 1000;
            end
            m_mv_act[p] = 0; m_sh_act[p] = 0;
            e_up[p] = 0; e_down[p] = 0; e_sh[p] = 0;
        end
    endtask

    task automatic model_edge();
        bit r_up, r_dn, r_sh, held, diff;
        int k;
        m_n++;
        m_raw[0] = {btn_p1_shoot, btn_p1_down, btn_p1_up};
        m_raw[1] = {btn_p2_shoot, btn_p2_down, btn_p2_up};
        for (int p = 0; p < 2; p++) begin
            r_up = m_db[p][0] & ~m_dbp[p][0];
            r_dn = m_db[p][1] & ~m_dbp[p][1];
            r_sh = m_db[p][2] & ~m_dbp[p][2];
            e_up[p] = 0; e_down[p] = 0;
            if (m_mv_act[p]) begin
                held = m_mv_up[p] ? m_db[p][0] : m_db[p][1];
                if (!game_en || !held || (m_db[p][0] && m_db[p][1])) begin
                    m_mv_act[p] = 0;
                end else begin
                    k = m_n - m_mv_t0[p];
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
                    if (k == RD || (k > RD && (k - RD) % RP == 0)) begin
                        e_up[p] = m_mv_up[p]; e_down[p] = !m_mv_up[p];
                    end
`endif
                end
            end
            if (!m_mv_act[p] && game_en) begin
                if (r_up && !m_db[p][1]) begin
                    m_mv_act[p] = 1; m_mv_up[p] = 1; m_mv_t0[p] = m_n; e_up[p] = 1;
                end else if (r_dn && !m_db[p][0]) begin
                    m_mv_act[p] = 1; m_mv_up[p] = 0; m_mv_t0[p] = m_n; e_down[p] = 1;
                end
            end
            if (!game_en) begin
                m_sh_act[p] = 0; e_sh[p] = 0;
            end else if (m_sh_act[p] && (m_n - m_sh_t0[p]) < HOLD) begin
                e_sh[p] = 1;
            end else if (m_sh_act[p]) begin
                m_sh_act[p] = 0; e_sh[p] = 0;
            end else if (r_sh) begin
                m_sh_act[p] = 1; m_sh_t0[p] = m_n; e_sh[p] = 1;
            end else begin
                e_sh[p] = 0;
            end
            for (int b = 0; b < 3; b++) begin
                m_hist[p][b] = {m_hist[p][b][30:0], m_raw[p][b]};
                m_since[p][b]++;
                m_dbp[p][b] = m_db[p][b];
                diff = 1;
                for (int i = 2; i <= DEB + 1; i++)
                    if (m_hist[p][b][i] == m_db[p][b]) diff = 0;
                if (diff && m_since[p][b] >= DEB) begin
                    m_db[p][b] = ~m_db[p][b];
                    m_since[p][b] = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("p1_up",    player1_up,   e_up[0]);
            check("p1_down",  player1_down, e_down[0]);
            check("p2_up",    player2_up,   e_up[1]);
            check("p2_down",  player2_down, e_down[1]);
            check("p1_shoot", player1Shoot, e_sh[0]);
            check("p2_shoot", player2Shoot, e_sh[1]);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int t0 = 0, p1_mv = 0, p2_up_cnt = 0, sh_hi = 0, sh_first = -1;
    bit rec_p2d = 0;
    int p2d_q[$];
    int exp_p2d[$];

    task automatic clear_tally();
        p1_mv = 0; p2_up_cnt = 0; sh_hi = 0; sh_first = -1;
        p2d_q.delete();
        t0 = cyc;
    endtask

    task automatic step(input int n);
        int rel;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (player2_down && rec_p2d) p2d_q.push_back(rel);
            if (player1Shoot) begin
                sh_hi++;
                if (sh_first < 0) sh_first = rel;
            end
            if (player1_up || player1_down) p1_mv++;
            if (player2_up) p2_up_cnt++;
        end
    endtask

    task automatic check_all_low(input string name);
        check(name, {player1_up, player1_down, player2_up, player2_down, player1Shoot, player2Shoot}, 0);
    endtask

    initial begin
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
        exp_p2d = '{7, 17, 22, 27, 32, 37};
`else
        exp_p2d = '{7};
`endif
        repeat (3) @(negedge clk);
        check("reset_p1_up", player1_up, 0);
        check("reset_p1_down", player1_down, 0);
        check("reset_p2_up", player2_up, 0);
        check("reset_p2_down", player2_down, 0);
        check("reset_p1_shoot", player1Shoot, 0);
        check("reset_p2_shoot", player2Shoot, 0);
        rst_n = 1'b1;
        step(5);

        // Bounce: 2-cycle runs never reach the debounce threshold.
        clear_tally();
        for (int i = 0; i < 10; i++) begin
            btn_p1_up = ~btn_p1_up;
            step(2);
        end
        btn_p1_up = 1'b0;
        step(10);
        check("bounce_no_pulse", p1_mv, 0);

        // Clean press with hold.
        clear_tally();
        rec_p2d = 1'b1;
        btn_p2_down = 1'b1;
        step(40);
        rec_p2d = 1'b0;
        check("p2d_pulse_count", p2d_q.size(), exp_p2d.size());
        for (int i = 0; i < exp_p2d.size() && i < p2d_q.size(); i++)
            check("p2d_pulse_edge", p2d_q[i], exp_p2d[i]);
        btn_p2_down = 1'b0;
        step(12);

        // Conflict: both directions together, then release only one.
        clear_tally();
        btn_p1_up = 1'b1; btn_p1_down = 1'b1;
        step(30);
        check("conflict_no_pulse", p1_mv, 0);
        btn_p1_down = 1'b0;
        step(15);
        check("conflict_release_no_pulse", p1_mv, 0);
        btn_p1_up = 1'b0;
        step(10);
        clear_tally();
        btn_p1_up = 1'b1;
        step(10);
        check("repress_one_pulse", p1_mv, 1);
        btn_p1_up = 1'b0;
        step(10);

        // Shoot: held button yields exactly HOLD cycles, then re-arm on a new press.
        clear_tally();
        btn_p1_shoot = 1'b1;
        step(20);
        check("shoot_start_edge", sh_first, 7);
        check("shoot_width", sh_hi, 6);
        btn_p1_shoot = 1'b0;
        step(10);
        clear_tally();
        btn_p1_shoot = 1'b1;
        step(15);
        check("shoot_rearm_start", sh_first, 7);
        check("shoot_rearm_width", sh_hi, 6);
        btn_p1_shoot = 1'b0;
        step(10);

        // game_en: drop mid-hold, then re-enable with buttons held.
        clear_tally();
        btn_p1_shoot = 1'b1;
        step(8);
        check("shoot_high_before_disable", player1Shoot, 1);
        game_en = 1'b0;
        step(1);
        check("shoot_drops_on_disable", player1Shoot, 0);
        btn_p2_up = 1'b1;
        step(12);
        game_en = 1'b1;
        clear_tally();
        step(20);
        check("enable_held_no_move", p2_up_cnt, 0);
        check("enable_held_no_shoot", sh_hi, 0);
        btn_p1_shoot = 1'b0; btn_p2_up = 1'b0;
        step(10);

        // Asynchronous reset in the middle of a repeat and a shoot hold.
        clear_tally();
        btn_p2_up = 1'b1;
        step(14);
        btn_p1_shoot = 1'b1;
        step(8);
        check("shoot_high_before_reset", player1Shoot, 1);
        #2 rst_n = 1'b0;
        #1 check_all_low("async_reset_outputs");
        btn_p2_up = 1'b0; btn_p1_shoot = 1'b0;
        step(3);
        rst_n = 1'b1;
        clear_tally();
        step(15);
        check("post_reset_quiet", p2_up_cnt + sh_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
